mem_cache_ctrl: RTL and testbench

MEM_CACHE_CTRL -- requirements
Module: mem_cache_ctrl

---
 rtl/mem_cache_ctrl.sv | 169 ++++++++++++++++
 tb/tb_mem_cache_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mem_cache_ctrl.sv
// Direct-mapped, one-word-per-line, write-through / no-write-allocate data cache
// controller sitting between the pipeline load/store stage and a single-port backing memory.
module mem_cache_ctrl #(
    parameter int SETS   = 16,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic [2:0]        mem_write_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic [3:0]        mem_be_o,
    input  logic [31:0]       mem_rdata_i,
    input  logic              mem_ready_i,
    output logic [CNT_W-1:0]  hit_cnt_o,
    output logic [CNT_W-1:0]  miss_cnt_o
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REFILL = 2'd1;
    localparam logic [1:0] S_WRITE  = 2'd2;

    logic [1:0]        state;
    logic [SETS-1:0]   valid_arr;
    logic [TAG_W-1:0]  tag_arr  [SETS];
    logic [31:0]       data_arr [SETS];

    // Request captured on leaving IDLE so the bus stays stable for the whole transaction.
    logic [ADDR_W-3:0] req_word;
    logic [31:0]       req_wdata;
    logic [3:0]        req_be;

    logic [IDX_W-1:0]  cur_idx;
    logic [TAG_W-1:0]  cur_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic              is_store;
    logic              cur_hit;
    logic              req_hit;
    logic              start_txn;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [3:0] calc_be(input logic [1:0] kind, input logic [1:0] offs);
        case (kind)
            2'b01:   return 4'b0001 << offs;
            2'b10:   return offs[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [1:0] kind, input logic [31:0] wd);
        case (kind)
            2'b01:   return {4{wd[7:0]}};
            2'b10:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] merge_word(input logic [31:0] old, input logic [31:0] wd,
                                               input logic [3:0] be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++)
            res[8*i +: 8] = be[i] ? wd[8*i +: 8] : old[8*i +: 8];
        return res;
    endfunction

    assign cur_idx   = addr_i[IDX_W+1:2];
    assign cur_tag   = addr_i[ADDR_W-1:IDX_W+2];
    assign req_idx   = req_word[IDX_W-1:0];
    assign req_tag   = req_word[ADDR_W-3:IDX_W];
    assign is_store  = !mem_write_i[2] && (mem_write_i[1:0] != 2'b00);
    assign cur_hit   = valid_arr[cur_idx] && (tag_arr[cur_idx] == cur_tag);
    assign req_hit   = valid_arr[req_idx] && (tag_arr[req_idx] == req_tag);
    assign start_txn = (state == S_IDLE) && en_i && (is_store || !cur_hit);

    always_comb begin
        stall_o     = 1'b0;
        rdata_o     = data_arr[cur_idx];
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = {req_word, 2'b00};
        mem_wdata_o = req_wdata;
        mem_be_o    = 4'b1111;
        case (state)
            S_IDLE: begin
                if (en_i)
                    stall_o = is_store || !cur_hit;
            end
            S_REFILL: begin
                mem_req_o = 1'b1;
                stall_o   = !mem_ready_i;
                if (mem_ready_i)
                    rdata_o = mem_rdata_i;
            end
            S_WRITE: begin
                mem_req_o = 1'b1;
                mem_we_o  = 1'b1;
                mem_be_o  = req_be;
                stall_o   = !mem_ready_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            valid_arr  <= '0;
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (en_i) begin
                        if (is_store) begin
                            state <= S_WRITE;
                        end else if (cur_hit) begin
                            hit_cnt_o <= sat_inc(hit_cnt_o);
                        end else begin
                            state      <= S_REFILL;
                            miss_cnt_o <= sat_inc(miss_cnt_o);
                        end
                    end
                end
                S_REFILL: begin
                    if (mem_ready_i) begin
                        state              <= S_IDLE;
                        valid_arr[req_idx] <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (mem_ready_i)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Datapath storage carries no reset; an aborted transaction must still not touch the line.
    always_ff @(posedge clk) begin
        if (start_txn) begin
            req_word  <= addr_i[ADDR_W-1:2];
            req_wdata <= lane_data(mem_write_i[1:0], wdata_i);
            req_be    <= is_store ? calc_be(mem_write_i[1:0], addr_i[1:0]) : 4'b1111;
        end
        if (!rst && state == S_REFILL && mem_ready_i) begin
            data_arr[req_idx] <= mem_rdata_i;
            tag_arr[req_idx]  <= req_tag;
        end
        if (!rst && state == S_WRITE && mem_ready_i && req_hit)
            data_arr[req_idx] <= merge_word(data_arr[req_idx], req_wdata, req_be);
    end

endmodule

// File: tb/tb_mem_cache_ctrl.sv
// Directed bench for mem_cache_ctrl: cold/warm loads, store merging, eviction,
// reset abort, enable gating and counter saturation (narrow counters).
module tb_mem_cache_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             en_i;
    logic [2:0]       mem_write_i;
    logic [31:0]      addr_i;
    logic [31:0]      wdata_i;
    logic [31:0]      rdata_o;
    logic             stall_o;
    logic             mem_req_o;
    logic             mem_we_o;
    logic [31:0]      mem_addr_o;
    logic [31:0]      mem_wdata_o;
    logic [3:0]       mem_be_o;
    logic [31:0]      mem_rdata_i;
    logic             mem_ready_i;
    logic [CNT_W-1:0] hit_cnt_o;
    logic [CNT_W-1:0] miss_cnt_o;

    int n_chk  = 0;
    int n_fail = 0;

    mem_cache_ctrl #(.SETS(16), .ADDR_W(32), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .en_i(en_i), .mem_write_i(mem_write_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .stall_o(stall_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i),
        .mem_ready_i(mem_ready_i), .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // All tasks start at a falling edge and return at a falling edge with en_i low.
    task automatic load_miss(input logic [31:0] a, input logic [31:0] d, input int waits);
        en_i = 1'b1; mem_write_i = 3'b000; addr_i = a; mem_ready_i = 1'b0; #1;
        chk("miss_stall_idle", {31'd0, stall_o}, 32'd1);
        chk("miss_req_idle", {31'd0, mem_req_o}, 32'd0);
        for (int i = 0; i < waits; i++) begin
            @(negedge clk); #1;
            chk("refill_stall", {31'd0, stall_o}, 32'd1);
            chk("refill_req", {31'd0, mem_req_o}, 32'd1);
            chk("refill_we", {31'd0, mem_we_o}, 32'd0);
            chk("refill_be", {28'd0, mem_be_o}, 32'hF);
        end
        @(negedge clk);
        mem_ready_i = 1'b1; mem_rdata_i = d; #1;
        chk("refill_done_stall", {31'd0, stall_o}, 32'd0);
        chk("refill_done_rdata", rdata_o, d);
        chk("refill_done_req", {31'd0, mem_req_o}, 32'd1);
        chk("refill_addr", mem_addr_o, {a[31:2], 2'b00});
        @(negedge clk);
        mem_ready_i = 1'b0; en_i = 1'b0;
    endtask

    task automatic load_hit(input logic [31:0] a, input logic [2:0] mw, input logic [31:0] d);
        en_i = 1'b1; mem_write_i = mw; addr_i = a; #1;
        chk("hit_stall", {31'd0, stall_o}, 32'd0);
        chk("hit_req", {31'd0, mem_req_o}, 32'd0);
        chk("hit_rdata", rdata_o, d);
        @(negedge clk);
        en_i = 1'b0; mem_write_i = 3'b000;
    endtask

    task automatic store(input logic [2:0] mw, input logic [31:0] a, input logic [31:0] w,
                         input logic [3:0] be, input logic [31:0] wd);
        en_i = 1'b1; mem_write_i = mw; addr_i = a; wdata_i = w; mem_ready_i = 1'b0; #1;
        chk("st_stall_idle", {31'd0, stall_o}, 32'd1);
        chk("st_req_idle", {31'd0, mem_req_o}, 32'd0);
        @(negedge clk); #1;
        chk("st_req", {31'd0, mem_req_o}, 32'd1);
        chk("st_we", {31'd0, mem_we_o}, 32'd1);
        chk("st_be", {28'd0, mem_be_o}, {28'd0, be});
        chk("st_wdata", mem_wdata_o, wd);
        chk("st_addr", mem_addr_o, {a[31:2], 2'b00});
        chk("st_stall_wait", {31'd0, stall_o}, 32'd1);
        mem_ready_i = 1'b1; #1;
        chk("st_stall_done", {31'd0, stall_o}, 32'd0);
        @(negedge clk);
        mem_ready_i = 1'b0; en_i = 1'b0; mem_write_i = 3'b000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en_i = 1'b0; mem_write_i = 3'b000; addr_i = 32'd0; wdata_i = 32'd0;
        mem_rdata_i = 32'd0; mem_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_hit_cnt", {28'd0, hit_cnt_o}, 32'd0);
        chk("rst_miss_cnt", {28'd0, miss_cnt_o}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Cold miss with two wait cycles, then warm hit.
        load_miss(32'h40, 32'hDEADBEEF, 2);
        chk("cold_miss_cnt", {28'd0, miss_cnt_o}, 32'd1);
        chk("cold_hit_cnt", {28'd0, hit_cnt_o}, 32'd0);
        load_hit(32'h40, 3'b000, 32'hDEADBEEF);
        chk("warm_hit_cnt", {28'd0, hit_cnt_o}, 32'd1);

        // Byte store hit merges lane 2.
        store(3'b001, 32'h42, 32'h000000AB, 4'b0100, 32'hABABABAB);
        load_hit(32'h40, 3'b000, 32'hDEABBEEF);
        chk("merge_hit_cnt", {28'd0, hit_cnt_o}, 32'd2);

        // Half store miss does not allocate.
        store(3'b010, 32'h46, 32'h00001234, 4'b1100, 32'h12341234);
        load_miss(32'h44, 32'h55667788, 0);
        chk("noalloc_miss_cnt", {28'd0, miss_cnt_o}, 32'd2);

        // Word, low-half and top-byte stores on a hit line.
        store(3'b011, 32'h44, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D);
        load_hit(32'h44, 3'b000, 32'hCAFEF00D);
        store(3'b010, 32'h44, 32'h9999BEEF, 4'b0011, 32'hBEEFBEEF);
        load_hit(32'h44, 3'b000, 32'hCAFEBEEF);
        store(3'b001, 32'h47, 32'h00000011, 4'b1000, 32'h11111111);
        load_hit(32'h44, 3'b000, 32'h11FEBEEF);

        // Access type 1xx behaves as a load.
        load_hit(32'h40, 3'b100, 32'hDEABBEEF);
        chk("ld_alias_hit_cnt", {28'd0, hit_cnt_o}, 32'd6);

        // Disabled: no stall, no request, counters untouched.
        en_i = 1'b0; mem_write_i = 3'b000; addr_i = 32'h80; #1;
        chk("dis_ld_stall", {31'd0, stall_o}, 32'd0);
        chk("dis_ld_req", {31'd0, mem_req_o}, 32'd0);
        @(negedge clk);
        mem_write_i = 3'b011; #1;
        chk("dis_st_stall", {31'd0, stall_o}, 32'd0);
        @(negedge clk);
        mem_write_i = 3'b000;
        chk("dis_hit_cnt", {28'd0, hit_cnt_o}, 32'd6);
        chk("dis_miss_cnt", {28'd0, miss_cnt_o}, 32'd2);

        // Conflict on index 0: 0x80 evicts 0x40.
        load_miss(32'h80, 32'h80808080, 1);
        load_hit(32'h80, 3'b000, 32'h80808080);
        load_miss(32'h40, 32'h40404040, 0);
        chk("evict_miss_cnt", {28'd0, miss_cnt_o}, 32'd4);
        chk("evict_hit_cnt", {28'd0, hit_cnt_o}, 32'd7);

        // Reset in the middle of a refill.
        en_i = 1'b1; mem_write_i = 3'b000; addr_i = 32'hC0; mem_ready_i = 1'b0;
        @(negedge clk); #1;
        chk("abort_req_before", {31'd0, mem_req_o}, 32'd1);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("abort_req_after", {31'd0, mem_req_o}, 32'd0);
        chk("abort_hit_cnt", {28'd0, hit_cnt_o}, 32'd0);
        chk("abort_miss_cnt", {28'd0, miss_cnt_o}, 32'd0);
        rst = 1'b0; en_i = 1'b0;
        @(negedge clk);
        load_miss(32'h40, 32'hDEADBEEF, 1);
        chk("post_rst_miss_cnt", {28'd0, miss_cnt_o}, 32'd1);

        // Drive the miss counter to all-ones, then one more miss.
        for (int i = 0; i < 14; i++)
            load_miss((i % 2 == 0) ? 32'h80 : 32'h40, i, 0);
        chk("sat_reach", {28'd0, miss_cnt_o}, 32'd15);
        load_miss(32'h80, 32'h12345678, 0);
        chk("sat_hold", {28'd0, miss_cnt_o}, 32'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
